data_uncache_unit: RTL
======================

Name: data_uncache_unit

Overview:
- Data-side responder for the memory stage. Serves the request/addr_ok/data_ok/rdata handshake as an uncached, one-outstanding-request unit and returns data_ok/rdata/dcache_miss to the memory stage.
- Takes the memory-stage cancel (tlb_excp_cancel_req) one cycle after acceptance, and takes pipeline flushes.
- Converts each surviving access into a single read or write transaction on a simple memory-bus interface, placed between the CPU core and the AXI bridge.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; only 32 is supported.
- WAIT_WR_DONE, 1, 1 = store data_ok waits for wr_done; 0 = store data_ok follows wr_rdy (posted write).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- data_req  in  1  CPU access request.
- data_wr  in  1  1 = store, 0 = load.
- data_size  in  2  0 byte, 1 half, 2 word.
- data_addr  in  ADDR_W  physical byte address.
- data_wstrb  in  4  store byte enables.
- data_wdata  in  DATA_W  store data.
- data_addr_ok  out  1  request accepted this cycle.
- data_data_ok  out  1  one-cycle completion pulse.
- data_rdata  out  DATA_W  load data, valid with data_data_ok.
- dcache_miss  out  1  high with data_data_ok (every uncached access counts as a miss).
- tlb_excp_cancel_req  in  1  cancel of the request accepted in the previous cycle.
- flush  in  1  pipeline flush (exception, ertn, refetch, icacop).
- busy  out  1  state != IDLE.
- rd_req  out  1  bus read request.
- rd_addr  out  ADDR_W  bus read address.
- rd_size  out  3  {1'b0, size}.
- rd_rdy  in  1  read request accepted.
- ret_valid  in  1  read data return.
- ret_data  in  DATA_W  returned read data.
- wr_req  out  1  bus write request.
- wr_addr  out  ADDR_W  bus write address.
- wr_size  out  3  {1'b0, size}.
- wr_wstrb  out  4  bus write strobes.
- wr_data  out  DATA_W  bus write data.
- wr_rdy  in  1  write request accepted.
- wr_done  in  1  write response.

Behaviour:
- Reset: state IDLE; kill_r=0; all outputs 0; latched request registers 0.
- States: IDLE, LOOKUP, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
- IDLE:
  - data_addr_ok = data_req & !flush.
  - On accept: latch addr, wr, size, wstrb, wdata; go to LOOKUP.
  - No new request is accepted in any other state (one outstanding).
- LOOKUP (exactly 1 cycle):
  - tlb_excp_cancel_req | flush -> IDLE. No bus activity, no data_ok.
  - Otherwise wr_r ? WR_REQ : RD_REQ.
- RD_REQ:
  - rd_req=1; address/size held stable until rd_rdy.
  - On rd_rdy -> RD_WAIT.
- RD_WAIT:
  - On ret_valid: rdata_r <= ret_data; go to DONE, or to IDLE if kill.
  - ret_valid never arrives in the same cycle as rd_rdy (bus rule); stray ret_valid in any other state is ignored.
- WR_REQ:
  - wr_req=1; address/size/wstrb/data held stable until wr_rdy.
  - On wr_rdy -> WR_WAIT if WAIT_WR_DONE, else DONE (or IDLE if kill).
- WR_WAIT: on wr_done -> DONE, or IDLE if kill.
- DONE:
  - data_data_ok=1 and dcache_miss=1 for one cycle.
  - data_rdata = rdata_r for loads, 0 for stores.
  - Next state IDLE.
  - Flush in DONE suppresses data_ok; state still returns to IDLE.
- Kill handling:
  - kill = flush | kill_r.
  - kill_r sets on flush in RD_REQ/RD_WAIT/WR_REQ/WR_WAIT and clears on IDLE entry.
  - A bus transaction already requested is never abandoned: the request is held until rdy and the response is drained, then dropped silently.
- Simultaneous events:
  - flush with rd_rdy/ret_valid: the transition is taken and kill applies.
  - cancel and flush together in LOOKUP: drop, same as either alone.
- Latency, read with rdy/ret immediate: accept T, LOOKUP T+1, RD_REQ T+2, ret_valid T+3, data_ok T+4.
- Latency, store with WAIT_WR_DONE=0: data_ok T+3.
- data_data_ok is never asserted for a cancelled or flushed request; at most one data_ok per accepted request.

Decomposition:
- Shared package/header: state encodings; size encodings (SIZE_B=0, SIZE_H=1, SIZE_W=2); bus size width.
- Single module; no sub-module is natural.

Test Plan:
- Load word, addr 0x1C000010, rd_rdy immediate, ret_data=0xDEADBEEF at next cycle -> addr_ok at T; rd_req at T+2 with rd_size=3'd2; data_ok=1, dcache_miss=1, rdata=0xDEADBEEF at T+4 only.
- Store byte, addr 0x1C000003, wstrb=4'b1000, wdata=0x55000000, wr_rdy delayed 3 cycles, wr_done 2 cycles later, WAIT_WR_DONE=1 -> wr_req held with stable fields for 4 cycles; data_ok exactly the cycle after wr_done.
- Request with tlb_excp_cancel_req=1 at T+1 -> no rd_req/wr_req ever; no data_ok; busy drops at T+2; next request accepted at T+2.
- Flush while in RD_WAIT, ret_valid 5 cycles later -> no data_ok; state returns to IDLE after ret_valid; a following load returns its own data, not the stale data.
- data_req held high with flush=1 in IDLE -> addr_ok=0; reset asserted mid-RD_WAIT -> next cycle IDLE with all outputs 0.
- Back-to-back loads with data_req held -> second addr_ok the cycle after the first data_ok; never two outstanding requests.

Source files
------------

// File: rtl/data_uncache_unit_pkg.sv
// Shared encodings for the uncached data-side responder.
package data_uncache_unit_pkg;

  localparam int unsigned DSIZE_BITS = 2;
  localparam int unsigned BUS_SIZE_W = 3;
  localparam int unsigned STRB_W     = 4;

  // CPU access size encodings
  localparam logic [DSIZE_BITS-1:0] SIZE_B = 2'd0;
  localparam logic [DSIZE_BITS-1:0] SIZE_H = 2'd1;
  localparam logic [DSIZE_BITS-1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WR_WAIT = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Bus size field is the CPU size zero-extended
  function automatic logic [BUS_SIZE_W-1:0] bus_size(input logic [DSIZE_BITS-1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/data_uncache_unit.sv
// Uncached, single-outstanding data-side responder bridging the memory stage
// request/addr_ok/data_ok handshake onto a simple read/write memory bus.
module data_uncache_unit
  import data_uncache_unit_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter bit          WAIT_WR_DONE = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_req,
  input  logic                  data_wr,
  input  logic [DSIZE_BITS-1:0] data_size,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [STRB_W-1:0]     data_wstrb,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  dcache_miss,
  input  logic                  tlb_excp_cancel_req,
  input  logic                  flush,
  output logic                  busy,
  output logic                  rd_req,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [BUS_SIZE_W-1:0] rd_size,
  input  logic                  rd_rdy,
  input  logic                  ret_valid,
  input  logic [DATA_W-1:0]     ret_data,
  output logic                  wr_req,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [BUS_SIZE_W-1:0] wr_size,
  output logic [STRB_W-1:0]     wr_wstrb,
  output logic [DATA_W-1:0]     wr_data,
  input  logic                  wr_rdy,
  input  logic                  wr_done
);

  state_e                state, next_state;
  logic                  kill_r;
  logic                  kill;
  logic                  accept;
  logic                  wr_r;
  logic [DSIZE_BITS-1:0] size_r;
  logic [ADDR_W-1:0]     addr_r;
  logic [STRB_W-1:0]     wstrb_r;
  logic [DATA_W-1:0]     wdata_r;
  logic [DATA_W-1:0]     rdata_r;

  assign kill   = flush | kill_r;
  assign accept = (state == ST_IDLE) & data_req & ~flush;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs
  always_comb begin
    next_state   = state;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    dcache_miss  = 1'b0;
    data_rdata   = '0;
    rd_req       = 1'b0;
    wr_req       = 1'b0;
    busy         = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        data_addr_ok = accept;
        if (accept) next_state = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (tlb_excp_cancel_req | flush) next_state = ST_IDLE;
        else if (wr_r)                   next_state = ST_WR_REQ;
        else                             next_state = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        rd_req = 1'b1;
        if (rd_rdy) next_state = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (ret_valid) next_state = kill ? ST_IDLE : ST_DONE;
      end
      ST_WR_REQ: begin
        wr_req = 1'b1;
        if (wr_rdy) begin
          if (WAIT_WR_DONE) next_state = ST_WR_WAIT;
          else              next_state = kill ? ST_IDLE : ST_DONE;
        end
      end
      ST_WR_WAIT: begin
        if (wr_done) next_state = kill ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        // A flush landing on the completion cycle still swallows the pulse
        data_data_ok = ~flush;
        dcache_miss  = ~flush;
        data_rdata   = (~flush & ~wr_r) ? rdata_r : '0;
        next_state   = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Latch the accepted request; held stable for the whole bus transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_r    <= 1'b0;
      size_r  <= '0;
      addr_r  <= '0;
      wstrb_r <= '0;
      wdata_r <= '0;
    end else if (accept) begin
      wr_r    <= data_wr;
      size_r  <= data_size;
      addr_r  <= data_addr;
      wstrb_r <= data_wstrb;
      wdata_r <= data_wdata;
    end
  end

  // Remember a flush that hit an in-flight bus transaction until it drains
  always_ff @(posedge clk) begin
    if (reset)                    kill_r <= 1'b0;
    else if (next_state == ST_IDLE) kill_r <= 1'b0;
    else if (flush && (state == ST_RD_REQ || state == ST_RD_WAIT ||
                       state == ST_WR_REQ || state == ST_WR_WAIT))
      kill_r <= 1'b1;
  end

  // Capture returned read data
  always_ff @(posedge clk) begin
    if (reset)                                 rdata_r <= '0;
    else if (state == ST_RD_WAIT && ret_valid) rdata_r <= ret_data;
  end

  assign rd_addr  = addr_r;
  assign rd_size  = bus_size(size_r);
  assign wr_addr  = addr_r;
  assign wr_size  = bus_size(size_r);
  assign wr_wstrb = wstrb_r;
  assign wr_data  = wdata_r;

endmodule
